// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl - execute-stage initiator for the SigmaCore ALU.
//
// Accepts one decoded RV32I OP / OP-IMM instruction with its register
// operands, drives the external combinational ALU for exactly one cycle,
// then registers the result, flags and tag as a response to writeback.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The sender holds its payload while valid && !ready. in_ready
// does not depend on in_valid, and out_valid does not depend on out_ready.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               request handshake
//   in_instr, in_rs1, in_rs2, in_tag  request payload
//   alu_operand1/2, alu_op          drive to the combinational ALU
//   alu_result, alu_zero/negative/overflow/carry  ALU outputs
//   out_valid/out_ready             response handshake
//   out_result, out_flags, out_tag, out_illegal  registered response
//   op_count                        completed legal operations (wrapping)

package sigma_pkg;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
endpackage

module alu_issue_ctrl
    import sigma_pkg::*;
#(
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      alu_operand1,
    output logic [31:0]      alu_operand2,
    output logic [3:0]       alu_op,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    input  logic             alu_negative,
    input  logic             alu_overflow,
    input  logic             alu_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [3:0]       out_flags,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t           state_q, state_d;
    logic [TAG_W-1:0] tag_q;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        dec_legal;
    logic [3:0]  dec_op;
    logic [31:0] dec_op2;
    logic        accept;
    logic        unused_fields;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];

    // rd/rs1 index fields are resolved upstream; only the values arrive here.
    assign unused_fields = ^{in_instr[19:15], in_instr[11:7]};

    // Decode straight from the request so the accept edge can latch the
    // final ALU controls.
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = ALU_ADD;
        dec_op2   = in_rs2;
        case (opcode)
            OPC_OP: begin
                case (f3)
                    3'b000: begin
                        dec_legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
                        dec_op    = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    end
                    3'b001: begin dec_legal = (f7 == F7_ZERO); dec_op = ALU_SLL; end
                    3'b100: begin dec_legal = (f7 == F7_ZERO); dec_op = ALU_XOR; end
                    3'b110: begin dec_legal = (f7 == F7_ZERO); dec_op = ALU_OR;  end
                    3'b111: begin dec_legal = (f7 == F7_ZERO); dec_op = ALU_AND; end
                    3'b101: begin
                        dec_legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
                        dec_op    = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                dec_op2 = {{20{in_instr[31]}}, in_instr[31:20]};
                case (f3)
                    3'b000: begin dec_legal = 1'b1; dec_op = ALU_ADD; end
                    3'b100: begin dec_legal = 1'b1; dec_op = ALU_XOR; end
                    3'b110: begin dec_legal = 1'b1; dec_op = ALU_OR;  end
                    3'b111: begin dec_legal = 1'b1; dec_op = ALU_AND; end
                    3'b001: begin
                        dec_op2   = {27'd0, in_instr[24:20]};
                        dec_legal = (f7 == F7_ZERO);
                        dec_op    = ALU_SLL;
                    end
                    3'b101: begin
                        dec_op2   = {27'd0, in_instr[24:20]};
                        dec_legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
                        dec_op    = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = dec_legal ? ISSUE : RESP;
            ISSUE:   state_d = RESP;
            RESP:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_operand1 <= 32'd0;
            alu_operand2 <= 32'd0;
            alu_op       <= ALU_ADD;
            tag_q        <= '0;
            out_valid    <= 1'b0;
            out_result   <= 32'd0;
            out_flags    <= 4'd0;
            out_tag      <= '0;
            out_illegal  <= 1'b0;
            op_count     <= '0;
        end else begin
            // ALU controls only move on a legal accept, so the ALU sees
            // registered operands for the whole ISSUE cycle.
            if (accept && dec_legal) begin
                alu_operand1 <= in_rs1;
                alu_operand2 <= dec_op2;
                alu_op       <= dec_op;
                tag_q        <= in_tag;
            end
            // Illegal requests skip the ALU and respond directly.
            if (accept && !dec_legal) begin
                out_valid   <= 1'b1;
                out_illegal <= 1'b1;
                out_result  <= 32'd0;
                out_flags   <= 4'd0;
                out_tag     <= in_tag;
            end
            if (state_q == ISSUE) begin
                out_valid   <= 1'b1;
                out_illegal <= 1'b0;
                out_result  <= alu_result;
                out_flags   <= {alu_zero, alu_negative, alu_overflow, alu_carry};
                out_tag     <= tag_q;
                op_count    <= op_count + CNT_W'(1);
            end
            if (state_q == RESP && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
